// File: rtl/frame_hold_timer_pkg.sv
// frame_hold_timer_pkg: shared video-timing defaults and hold-timer state encodings
package frame_hold_timer_pkg;
  localparam int Y_W_DEF      = 10;
  localparam int V_ACTIVE_DEF = 480;
  localparam int CNT_W_DEF    = 8;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } state_e;
endpackage

// File: rtl/frame_hold_timer_edge_det.sv
// frame_edge_det: one-cycle frame_start on the first active line after vertical blanking
//   pclk, rstn   clock / async active-low reset
//   y_pixel      current line from the timing generator
//   frame_start  high for the first active cycle following blanking
module frame_edge_det #(
  parameter int Y_W      = 10,
  parameter int V_ACTIVE = 480
) (
  input  logic           pclk,
  input  logic           rstn,
  input  logic [Y_W-1:0] y_pixel,
  output logic           frame_start
);
  logic yen, yen_q;
  assign yen = y_pixel < Y_W'(V_ACTIVE);
  // yen_q resets high so coming out of reset mid-frame never fakes a frame start
  always_ff @(posedge pclk or negedge rstn)
    if (!rstn) yen_q <= 1'b1;
    else yen_q <= yen;
  assign frame_start = yen & ~yen_q;
endmodule

// File: rtl/frame_hold_timer.sv
// frame_hold_timer: frame-aligned hold enable lasting a programmable number of whole frames
//   pclk, rstn             clock / async active-low reset
//   y_pixel                current line; < V_ACTIVE is active video
//   trig, retrig_en        start request; allow restart while holding
//   abort                  force release, highest priority
//   hold_frames            hold length, sampled on an accepted trig
//   hold_out, busy         hold enable; state != IDLE
//   done_pulse, frame_cnt  completion pulse; frames counted in current hold
module frame_hold_timer
  import frame_hold_timer_pkg::*;
#(
  parameter int Y_W      = Y_W_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             pclk,
  input  logic             rstn,
  input  logic [Y_W-1:0]   y_pixel,
  input  logic             trig,
  input  logic             retrig_en,
  input  logic             abort,
  input  logic [CNT_W-1:0] hold_frames,
  output logic             hold_out,
  output logic             busy,
  output logic             done_pulse,
  output logic [CNT_W-1:0] frame_cnt
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic hold_q, hold_d, done_q, done_d;
  logic frame_start, load;
  frame_edge_det #(.Y_W(Y_W), .V_ACTIVE(V_ACTIVE)) u_edge (
    .pclk        (pclk),
    .rstn        (rstn),
    .y_pixel     (y_pixel),
    .frame_start (frame_start)
  );
  assign load = trig && |hold_frames;
  always_ff @(posedge pclk or negedge rstn)
    if (!rstn) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      hold_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (load) begin
          state_d = ARMED;
          len_d   = hold_frames;
        end
        ARMED: begin
          if (load) len_d = hold_frames;
          if (frame_start) begin
            state_d = HOLD;
            hold_d  = 1'b1;
            cnt_d   = CNT_W'(1);
          end
        end
        HOLD: begin
          // a restart discards the partial frame and beats a coincident final frame start
          if (load && retrig_en) begin
            len_d = hold_frames;
            cnt_d = '0;
          end else if (frame_start) begin
            if (cnt_q == len_q) begin
              state_d = IDLE;
              hold_d  = 1'b0;
              cnt_d   = '0;
              done_d  = 1'b1;
            end else cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  assign hold_out   = hold_q;
  assign done_pulse = done_q;
  assign frame_cnt  = cnt_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_frame_hold_timer.sv
// tb_frame_hold_timer: scoreboard bench; stimulus queues expected output changes, monitor pops on each change
module tb_frame_hold_timer;
  logic pclk = 1'b0;
  logic rstn = 1'b0;
  logic [10:0] y_pixel = 11'd720;
  logic trig = 1'b0, retrig_en = 1'b0, abort = 1'b0;
  logic [7:0] hold_frames = 8'd0;
  logic hold_out, busy, done_pulse;
  logic [7:0] frame_cnt;

  frame_hold_timer #(.Y_W(11), .V_ACTIVE(720), .CNT_W(8)) dut (
    .pclk        (pclk),
    .rstn        (rstn),
    .y_pixel     (y_pixel),
    .trig        (trig),
    .retrig_en   (retrig_en),
    .abort       (abort),
    .hold_frames (hold_frames),
    .hold_out    (hold_out),
    .busy        (busy),
    .done_pulse  (done_pulse),
    .frame_cnt   (frame_cnt)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int fr;
    int ps;
    logic h;
    logic d;
    logic b;
    logic [7:0] c;
  } ev_t;
  ev_t q[$];

  int f = 0, p = 0;
  logic blank_prev = 1'b1;
  int checks = 0, errors = 0;
  logic [10:0] ytab [6] = '{11'd0, 11'd1, 11'd2, 11'd719, 11'd720, 11'd720};

  task automatic exp_ev(input int ef, input int ep, input logic h, input logic d, input logic b, input logic [7:0] c);
    q.push_back('{fr: ef, ps: ep, h: h, d: d, b: b, c: c});
  endtask

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, got, want);
    end
  endtask

  // f/p name the frame and line whose inputs are applied this cycle
  task automatic step(input logic [10:0] y, input logic t, input logic a);
    @(negedge pclk);
    y_pixel = y;
    trig = t;
    abort = a;
    if (y < 11'd720 && blank_prev) begin
      f++;
      p = 0;
    end else p++;
    blank_prev = y >= 11'd720;
  endtask

  task automatic frame(input int tp, input int kind);
    for (int i = 0; i < 6; i++) step(ytab[i], kind == 1 && i == tp, kind == 2 && i == tp);
  endtask

  task automatic idle(input int n);
    repeat (n) frame(-1, 0);
  endtask

  initial begin : monitor
    logic [10:0] cur, prev;
    ev_t e;
    prev = '0;
    forever begin
      @(posedge pclk);
      #1;
      cur = {hold_out, done_pulse, busy, frame_cnt};
      if (rstn && cur !== prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event f=%0d p=%0d: got h=%b d=%b b=%b cnt=%0d, expected no change",
                   f, p, hold_out, done_pulse, busy, frame_cnt);
        end else begin
          e = q.pop_front();
          if (e.fr != f || e.ps != p || cur !== {e.h, e.d, e.b, e.c}) begin
            errors++;
            $display("FAIL event: got f=%0d p=%0d h=%b d=%b b=%b cnt=%0d, expected f=%0d p=%0d h=%b d=%b b=%b cnt=%0d",
                     f, p, hold_out, done_pulse, busy, frame_cnt, e.fr, e.ps, e.h, e.d, e.b, e.c);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin : stim
    int F;
    repeat (3) @(negedge pclk);
    chk("reset_hold", hold_out, 0);
    chk("reset_done", done_pulse, 0);
    chk("reset_busy", busy, 0);
    chk("reset_cnt", frame_cnt, 0);
    rstn = 1'b1;
    idle(1);
    // basic 3-frame hold, hold_frames change afterwards has no effect
    hold_frames = 8'd3;
    F = f + 1;
    exp_ev(F, 2, 0, 0, 1, 0);
    exp_ev(F + 1, 0, 1, 0, 1, 1);
    exp_ev(F + 2, 0, 1, 0, 1, 2);
    exp_ev(F + 3, 0, 1, 0, 1, 3);
    exp_ev(F + 4, 0, 0, 1, 0, 0);
    exp_ev(F + 4, 1, 0, 0, 0, 0);
    frame(2, 1);
    hold_frames = 8'd7;
    idle(5);
    // retrigger during frame 2 of 3
    retrig_en = 1'b1;
    hold_frames = 8'd3;
    F = f + 1;
    exp_ev(F, 2, 0, 0, 1, 0);
    exp_ev(F + 1, 0, 1, 0, 1, 1);
    exp_ev(F + 2, 0, 1, 0, 1, 2);
    exp_ev(F + 2, 2, 1, 0, 1, 0);
    exp_ev(F + 3, 0, 1, 0, 1, 1);
    exp_ev(F + 4, 0, 1, 0, 1, 2);
    exp_ev(F + 5, 0, 1, 0, 1, 3);
    exp_ev(F + 6, 0, 0, 1, 0, 0);
    exp_ev(F + 6, 1, 0, 0, 0, 0);
    frame(2, 1);
    frame(-1, 0);
    frame(2, 1);
    idle(5);
    // same stimulus, retrigger disabled
    retrig_en = 1'b0;
    F = f + 1;
    exp_ev(F, 2, 0, 0, 1, 0);
    exp_ev(F + 1, 0, 1, 0, 1, 1);
    exp_ev(F + 2, 0, 1, 0, 1, 2);
    exp_ev(F + 3, 0, 1, 0, 1, 3);
    exp_ev(F + 4, 0, 0, 1, 0, 0);
    exp_ev(F + 4, 1, 0, 0, 0, 0);
    frame(2, 1);
    frame(-1, 0);
    frame(2, 1);
    idle(3);
    // trig on a frame start while IDLE waits a full frame
    hold_frames = 8'd1;
    F = f + 1;
    exp_ev(F, 0, 0, 0, 1, 0);
    exp_ev(F + 1, 0, 1, 0, 1, 1);
    exp_ev(F + 2, 0, 0, 1, 0, 0);
    exp_ev(F + 2, 1, 0, 0, 0, 0);
    frame(0, 1);
    idle(3);
    // trig on a frame start while ARMED reloads and starts at once
    hold_frames = 8'd2;
    F = f + 1;
    exp_ev(F, 2, 0, 0, 1, 0);
    exp_ev(F + 1, 0, 1, 0, 1, 1);
    exp_ev(F + 2, 0, 0, 1, 0, 0);
    exp_ev(F + 2, 1, 0, 0, 0, 0);
    frame(2, 1);
    hold_frames = 8'd1;
    frame(0, 1);
    idle(3);
    // abort on the final frame start, then zero-length trig ignored
    hold_frames = 8'd2;
    F = f + 1;
    exp_ev(F, 2, 0, 0, 1, 0);
    exp_ev(F + 1, 0, 1, 0, 1, 1);
    exp_ev(F + 2, 0, 1, 0, 1, 2);
    exp_ev(F + 3, 0, 0, 0, 0, 0);
    frame(2, 1);
    frame(-1, 0);
    frame(-1, 0);
    frame(0, 2);
    hold_frames = 8'd0;
    frame(2, 1);
    idle(2);
    // retrigger beats a coincident final frame start
    retrig_en = 1'b1;
    hold_frames = 8'd1;
    F = f + 1;
    exp_ev(F, 2, 0, 0, 1, 0);
    exp_ev(F + 1, 0, 1, 0, 1, 1);
    exp_ev(F + 2, 0, 1, 0, 1, 0);
    exp_ev(F + 3, 0, 1, 0, 1, 1);
    exp_ev(F + 4, 0, 0, 1, 0, 0);
    exp_ev(F + 4, 1, 0, 0, 0, 0);
    frame(2, 1);
    frame(-1, 0);
    frame(0, 1);
    idle(3);
    // asynchronous reset mid-hold, released during active video
    retrig_en = 1'b0;
    hold_frames = 8'd3;
    F = f + 1;
    exp_ev(F, 2, 0, 0, 1, 0);
    exp_ev(F + 1, 0, 1, 0, 1, 1);
    frame(2, 1);
    step(11'd0, 1'b0, 1'b0);
    step(11'd1, 1'b0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_hold", hold_out, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_cnt", frame_cnt, 0);
    chk("async_rst_done", done_pulse, 0);
    step(11'd2, 1'b0, 1'b0);
    #2 rstn = 1'b1;
    step(11'd719, 1'b0, 1'b0);
    step(11'd720, 1'b0, 1'b0);
    step(11'd720, 1'b0, 1'b0);
    idle(2);
    chk("post_rst_hold", hold_out, 0);
    chk("post_rst_busy", busy, 0);
    // maximum length, no wrap
    hold_frames = 8'd255;
    F = f + 1;
    exp_ev(F, 2, 0, 0, 1, 0);
    for (int k = 1; k <= 255; k++) exp_ev(F + k, 0, 1, 0, 1, 8'(k));
    exp_ev(F + 256, 0, 0, 1, 0, 0);
    exp_ev(F + 256, 1, 0, 0, 0, 0);
    frame(2, 1);
    hold_frames = 8'd3;
    idle(258);
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
